// File: rtl/pipe_skid_reg.sv
// Single pipeline stage with a valid/ready handshake on both sides.
// SKID=1 gives a two-entry skid buffer whose in_ready_o comes straight from a flop; SKID=0 gives one entry with pass-through ready.
module pipe_skid_reg #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(32'h00000013),
    parameter bit               SKID      = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i,
    output logic [1:0]       occupancy_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_in_ready;
    logic             w_in_ready_nxt;
    logic [1:0]       r_occ;
    logic [1:0]       w_occ_nxt;
    logic             w_push;
    logic             w_pop;

    assign in_ready_o  = SKID ? r_in_ready : (~r_valid | out_ready_i);
    assign out_valid_o = r_valid;
    assign out_data_o  = r_main;
    assign occupancy_o = r_occ;

    assign w_push = in_valid_i & in_ready_o;
    assign w_pop  = r_valid & out_ready_i;

    // State and datapath registers; an empty slot always holds NOP_VALUE.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_main     <= NOP_VALUE;
            r_skid     <= NOP_VALUE;
            r_valid    <= 1'b0;
            r_in_ready <= 1'b1;
            r_occ      <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
            r_valid    <= w_valid_nxt;
            r_in_ready <= w_in_ready_nxt;
            r_occ      <= w_occ_nxt;
        end
    end

    // Next state; flush discards everything and overrides any handshake.
    always_comb begin
        w_state_nxt    = r_state;
        w_main_nxt     = r_main;
        w_skid_nxt     = r_skid;
        w_valid_nxt    = r_valid;
        w_in_ready_nxt = r_in_ready;
        w_occ_nxt      = r_occ;

        if (flush_i) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = NOP_VALUE;
            w_skid_nxt  = NOP_VALUE;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = in_data_i;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        w_main_nxt = in_data_i;
                    end else if (w_push && SKID) begin
                        w_state_nxt = ST_TWO;
                        w_skid_nxt  = in_data_i;
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                        w_main_nxt  = NOP_VALUE;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = NOP_VALUE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_main_nxt  = NOP_VALUE;
                    w_skid_nxt  = NOP_VALUE;
                end
            endcase
        end

        w_valid_nxt    = (w_state_nxt != ST_EMPTY);
        w_in_ready_nxt = (w_state_nxt != ST_TWO);
        case (w_state_nxt)
            ST_ONE:  w_occ_nxt = 2'd1;
            ST_TWO:  w_occ_nxt = 2'd2;
            default: w_occ_nxt = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios on 32-bit skid/no-skid
// stages, then a random scoreboard run on four instances of mixed width and mode.
module tb_pipe_skid_reg;

    localparam int unsigned N_DUT       = 4;
    localparam int unsigned RAND_CYCLES = 10000;
    localparam logic [63:0] NOP         = 64'h13;
    localparam bit          IS_SKID [N_DUT] = '{1'b1, 1'b0, 1'b1, 1'b0};

    logic        clk_i = 1'b0;
    logic        rst;
    logic        flush     [N_DUT];
    logic        in_valid  [N_DUT];
    logic        out_ready [N_DUT];
    logic [63:0] in_data   [N_DUT];
    logic        in_ready  [N_DUT];
    logic        out_valid [N_DUT];
    logic [63:0] out_data  [N_DUT];
    logic [1:0]  occ       [N_DUT];
    logic [63:0] mask      [N_DUT];

    logic [31:0] w0_data;
    logic [31:0] w1_data;
    logic [7:0]  w2_data;
    logic [63:0] w3_data;

    logic [63:0] sb [N_DUT][$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    assign out_data[0] = 64'(w0_data);
    assign out_data[1] = 64'(w1_data);
    assign out_data[2] = 64'(w2_data);
    assign out_data[3] = w3_data;

    pipe_skid_reg #(.WIDTH(32), .SKID(1'b1)) u_dut0 (
        .clk_i(clk_i), .rst(rst), .flush_i(flush[0]), .in_valid_i(in_valid[0]),
        .in_data_i(in_data[0][31:0]), .in_ready_o(in_ready[0]), .out_valid_o(out_valid[0]),
        .out_data_o(w0_data), .out_ready_i(out_ready[0]), .occupancy_o(occ[0]));

    pipe_skid_reg #(.WIDTH(32), .SKID(1'b0)) u_dut1 (
        .clk_i(clk_i), .rst(rst), .flush_i(flush[1]), .in_valid_i(in_valid[1]),
        .in_data_i(in_data[1][31:0]), .in_ready_o(in_ready[1]), .out_valid_o(out_valid[1]),
        .out_data_o(w1_data), .out_ready_i(out_ready[1]), .occupancy_o(occ[1]));

    pipe_skid_reg #(.WIDTH(8), .SKID(1'b1)) u_dut2 (
        .clk_i(clk_i), .rst(rst), .flush_i(flush[2]), .in_valid_i(in_valid[2]),
        .in_data_i(in_data[2][7:0]), .in_ready_o(in_ready[2]), .out_valid_o(out_valid[2]),
        .out_data_o(w2_data), .out_ready_i(out_ready[2]), .occupancy_o(occ[2]));

    pipe_skid_reg #(.WIDTH(64), .SKID(1'b0)) u_dut3 (
        .clk_i(clk_i), .rst(rst), .flush_i(flush[3]), .in_valid_i(in_valid[3]),
        .in_data_i(in_data[3]), .in_ready_o(in_ready[3]), .out_valid_o(out_valid[3]),
        .out_data_o(w3_data), .out_ready_i(out_ready[3]), .occupancy_o(occ[3]));

    task automatic cyc();
        @(negedge clk_i);
    endtask

    task automatic idle_all();
        for (int k = 0; k < int'(N_DUT); k++) begin
            flush[k]     = 1'b0;
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            in_data[k]   = 64'h0;
        end
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        for (int k = 0; k < int'(N_DUT); k++) begin
            n_checks++;
            if (out_valid[k] !== 1'b0) $display("FAIL reset_valid dut%0d: got %b want 0", k, out_valid[k]);
            else n_pass++;
            n_checks++;
            if (out_data[k] !== NOP) $display("FAIL reset_data dut%0d: got %h want %h", k, out_data[k], NOP);
            else n_pass++;
            n_checks++;
            if (in_ready[k] !== 1'b1) $display("FAIL reset_ready dut%0d: got %b want 1", k, in_ready[k]);
            else n_pass++;
            n_checks++;
            if (occ[k] !== 2'd0) $display("FAIL reset_occ dut%0d: got %0d want 0", k, occ[k]);
            else n_pass++;
        end
    endtask

    task automatic test_stream();
        logic [63:0] a [3];
        logic [63:0] exp_q [$];
        logic [63:0] exp;
        a[0] = 64'hA1A1_0001;
        a[1] = 64'hA2A2_0002;
        a[2] = 64'hA3A3_0003;
        idle_all();
        for (int i = 0; i < 3; i++) begin
            in_valid[0]  = 1'b1;
            in_data[0]   = a[i];
            out_ready[0] = 1'b1;
            #1;
            n_checks++;
            if (in_ready[0] !== 1'b1) $display("FAIL stream_ready beat%0d: got %b want 1", i, in_ready[0]);
            else n_pass++;
            exp_q.push_back(a[i]);
            if (i > 0) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (out_valid[0] !== 1'b1 || out_data[0] !== exp)
                    $display("FAIL stream_out beat%0d: got v=%b %h want v=1 %h", i, out_valid[0], out_data[0], exp);
                else n_pass++;
                n_checks++;
                if (occ[0] !== 2'd1) $display("FAIL stream_occ beat%0d: got %0d want 1", i, occ[0]);
                else n_pass++;
            end
            cyc();
        end
        in_valid[0] = 1'b0;
        exp = exp_q.pop_front();
        n_checks++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== exp)
            $display("FAIL stream_last: got v=%b %h want v=1 %h", out_valid[0], out_data[0], exp);
        else n_pass++;
        cyc();
        n_checks++;
        if (out_valid[0] !== 1'b0 || out_data[0] !== NOP || occ[0] !== 2'd0)
            $display("FAIL stream_drain: got v=%b %h occ=%0d want v=0 %h occ=0", out_valid[0], out_data[0], occ[0], NOP);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        idle_all();
        in_valid[0] = 1'b1;
        in_data[0]  = 64'hB1;
        cyc();
        in_data[0] = 64'hB2;
        n_checks++;
        if (occ[0] !== 2'd1 || in_ready[0] !== 1'b1 || out_data[0] !== 64'hB1)
            $display("FAIL bp_one: got occ=%0d rdy=%b %h want occ=1 rdy=1 b1", occ[0], in_ready[0], out_data[0]);
        else n_pass++;
        cyc();
        in_valid[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (occ[0] !== 2'd2 || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1 || out_data[0] !== 64'hB1)
                $display("FAIL bp_two hold%0d: got occ=%0d rdy=%b v=%b %h want occ=2 rdy=0 v=1 b1",
                         i, occ[0], in_ready[0], out_valid[0], out_data[0]);
            else n_pass++;
            cyc();
        end
        out_ready[0] = 1'b1;
        cyc();
        n_checks++;
        if (occ[0] !== 2'd1 || in_ready[0] !== 1'b1 || out_data[0] !== 64'hB2)
            $display("FAIL bp_pop1: got occ=%0d rdy=%b %h want occ=1 rdy=1 b2", occ[0], in_ready[0], out_data[0]);
        else n_pass++;
        cyc();
        n_checks++;
        if (out_valid[0] !== 1'b0 || out_data[0] !== NOP || occ[0] !== 2'd0)
            $display("FAIL bp_pop2: got v=%b %h occ=%0d want v=0 %h occ=0", out_valid[0], out_data[0], occ[0], NOP);
        else n_pass++;
    endtask

    task automatic test_flush();
        idle_all();
        in_valid[0] = 1'b1;
        in_data[0]  = 64'hC1;
        cyc();
        in_data[0] = 64'hC2;
        cyc();
        n_checks++;
        if (occ[0] !== 2'd2) $display("FAIL flush_setup: got occ=%0d want 2", occ[0]);
        else n_pass++;
        flush[0]     = 1'b1;
        in_data[0]   = 64'hC3;
        out_ready[0] = 1'b1;
        cyc();
        flush[0]    = 1'b0;
        in_valid[0] = 1'b0;
        n_checks++;
        if (occ[0] !== 2'd0 || out_valid[0] !== 1'b0 || out_data[0] !== NOP || in_ready[0] !== 1'b1)
            $display("FAIL flush_result: got occ=%0d v=%b %h rdy=%b want occ=0 v=0 %h rdy=1",
                     occ[0], out_valid[0], out_data[0], in_ready[0], NOP);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_checks++;
            if (out_valid[0] !== 1'b0 || out_data[0] === 64'hC3)
                $display("FAIL flush_c3_leak cyc%0d: got v=%b %h want v=0", i, out_valid[0], out_data[0]);
            else n_pass++;
        end
    endtask

    task automatic test_no_skid();
        idle_all();
        in_valid[1] = 1'b1;
        in_data[1]  = 64'hD1;
        cyc();
        in_data[1] = 64'hDD;
        #1;
        n_checks++;
        if (out_valid[1] !== 1'b1 || out_data[1] !== 64'hD1 || in_ready[1] !== 1'b0)
            $display("FAIL noskid_full: got v=%b %h rdy=%b want v=1 d1 rdy=0", out_valid[1], out_data[1], in_ready[1]);
        else n_pass++;
        cyc();
        n_checks++;
        if (occ[1] !== 2'd1 || out_data[1] !== 64'hD1)
            $display("FAIL noskid_hold: got occ=%0d %h want occ=1 d1", occ[1], out_data[1]);
        else n_pass++;
        out_ready[1] = 1'b1;
        in_data[1]   = 64'hD2;
        #1;
        n_checks++;
        if (in_ready[1] !== 1'b1) $display("FAIL noskid_comb_ready: got %b want 1", in_ready[1]);
        else n_pass++;
        cyc();
        in_valid[1] = 1'b0;
        n_checks++;
        if (out_valid[1] !== 1'b1 || out_data[1] !== 64'hD2 || occ[1] !== 2'd1)
            $display("FAIL noskid_d2: got v=%b %h occ=%0d want v=1 d2 occ=1", out_valid[1], out_data[1], occ[1]);
        else n_pass++;
        cyc();
        n_checks++;
        if (out_valid[1] !== 1'b0 || out_data[1] !== NOP)
            $display("FAIL noskid_drain: got v=%b %h want v=0 %h", out_valid[1], out_data[1], NOP);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        idle_all();
        in_valid[0] = 1'b1;
        in_data[0]  = 64'hE1;
        cyc();
        in_data[0] = 64'hE2;
        cyc();
        rst          = 1'b1;
        flush[0]     = 1'b0;
        in_data[0]   = 64'hE3;
        out_ready[0] = 1'b1;
        cyc();
        rst = 1'b0;
        idle_all();
        n_checks++;
        if (occ[0] !== 2'd0 || out_valid[0] !== 1'b0 || out_data[0] !== NOP || in_ready[0] !== 1'b1)
            $display("FAIL rst_mid: got occ=%0d v=%b %h rdy=%b want occ=0 v=0 %h rdy=1",
                     occ[0], out_valid[0], out_data[0], in_ready[0], NOP);
        else n_pass++;
        cyc();
        n_checks++;
        if (out_valid[0] !== 1'b0) $display("FAIL rst_mid_quiet: got v=%b want 0", out_valid[0]);
        else n_pass++;
    endtask

    task automatic test_random();
        logic        prev_stall [N_DUT];
        logic [63:0] prev_data  [N_DUT];
        int          n;
        logic        exp_ready;
        logic [63:0] exp_data;
        logic        push;
        logic        pop;
        idle_all();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int k = 0; k < int'(N_DUT); k++) begin
            sb[k].delete();
            prev_stall[k] = 1'b0;
            prev_data[k]  = NOP;
        end
        for (int c = 0; c < int'(RAND_CYCLES); c++) begin
            for (int k = 0; k < int'(N_DUT); k++) begin
                in_valid[k]  = ($urandom_range(0, 9) < 7);
                out_ready[k] = ($urandom_range(0, 9) < 5);
                flush[k]     = ($urandom_range(0, 99) == 0);
                in_data[k]   = {$urandom, $urandom};
            end
            #1;
            for (int k = 0; k < int'(N_DUT); k++) begin
                n         = sb[k].size();
                exp_data  = (n > 0) ? sb[k][0] : NOP;
                exp_ready = IS_SKID[k] ? (n < 2) : ((n == 0) || out_ready[k]);
                n_checks++;
                if (out_valid[k] !== (n > 0) || out_data[k] !== exp_data)
                    $display("FAIL rand_out dut%0d cyc%0d: got v=%b %h want v=%b %h",
                             k, c, out_valid[k], out_data[k], (n > 0), exp_data);
                else n_pass++;
                n_checks++;
                if (occ[k] !== 2'(n) || in_ready[k] !== exp_ready)
                    $display("FAIL rand_ctl dut%0d cyc%0d: got occ=%0d rdy=%b want occ=%0d rdy=%b",
                             k, c, occ[k], in_ready[k], n, exp_ready);
                else n_pass++;
                if (prev_stall[k]) begin
                    n_checks++;
                    if (out_data[k] !== prev_data[k])
                        $display("FAIL rand_stall dut%0d cyc%0d: got %h want %h", k, c, out_data[k], prev_data[k]);
                    else n_pass++;
                end
                push = in_valid[k] & exp_ready;
                pop  = (n > 0) & out_ready[k];
                prev_stall[k] = (n > 0) & ~out_ready[k] & ~flush[k];
                prev_data[k]  = exp_data;
                if (flush[k]) begin
                    sb[k].delete();
                end else begin
                    if (pop) void'(sb[k].pop_front());
                    if (push) sb[k].push_back(in_data[k] & mask[k]);
                end
            end
            cyc();
        end
        idle_all();
    endtask

    initial begin
        mask[0] = 64'h0000_0000_FFFF_FFFF;
        mask[1] = 64'h0000_0000_FFFF_FFFF;
        mask[2] = 64'h0000_0000_0000_00FF;
        mask[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        rst = 1'b1;
        idle_all();
        cyc();
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_no_skid();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (1..1024).
REQ-002 SHALL have parameter NOP_VALUE, default 32'h00000013, payload driven when the stage holds no valid entry.
REQ-003 SHALL have parameter SKID, default 1: 1 = two-entry skid buffer; 0 = single-entry register with combinational ready.
REQ-004 clk_i  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush_i  input  1  synchronous kill of all held entries.
REQ-007 in_valid_i  input  1  upstream entry valid.
REQ-008 in_data_i  input  WIDTH  upstream payload.
REQ-009 in_ready_o  output  1  stage can accept this cycle.
REQ-010 out_valid_o  output  1  head entry valid.
REQ-011 out_data_o  output  WIDTH  head payload.
REQ-012 out_ready_i  input  1  downstream accepts head this cycle.
REQ-013 occupancy_o  output  2  number of held entries (0..2).

Function
REQ-014 Push SHALL occur when in_valid_i & in_ready_o; pop SHALL occur when out_valid_o & out_ready_i.
REQ-015 SKID=1 state machine SHALL use three states: EMPTY, ONE (main reg valid), TWO (main and skid regs valid).
REQ-016 EMPTY: push -> ONE, main <= in_data_i; no push -> EMPTY.
REQ-017 ONE: push & pop -> ONE, main <= in_data_i; push only -> TWO, skid <= in_data_i; pop only -> EMPTY; neither -> ONE.
REQ-018 TWO: pop -> ONE, main <= skid; no pop -> TWO; no push is possible in TWO.
REQ-019 SKID=1: in_ready_o SHALL be a registered function of state only (1 in EMPTY/ONE, 0 in TWO), with no combinational path from out_ready_i.
REQ-020 SKID=0: single entry; in_ready_o = ~out_valid_o | out_ready_i (combinational); push loads main, pop without push empties.
REQ-021 Ordering SHALL be strict FIFO; no entry is dropped or duplicated except by flush_i/rst.
REQ-022 Latency: an entry pushed in cycle N SHALL appear on out_valid_o/out_data_o in cycle N+1 when the stage was EMPTY.
REQ-023 Throughput SHALL be one entry per cycle while out_ready_i stays high.
REQ-024 out_data_o SHALL equal NOP_VALUE whenever out_valid_o = 0; the skid register SHALL read as NOP_VALUE when invalid.
REQ-025 occupancy_o SHALL be 0/1/2 for EMPTY/ONE/TWO (SKID=0: 0/1).
REQ-026 flush_i SHALL return the stage to EMPTY next cycle, discard both entries, and override a same-cycle push and pop; in_ready_o is 1 in the cycle after a flush.
REQ-027 A pop and a push in the same cycle SHALL both take effect (no bubble inserted).
REQ-028 Output payload SHALL not change while out_valid_o = 1 and out_ready_i = 0.

Reset
REQ-029 rst SHALL take priority over flush_i and all handshakes.
REQ-030 On rst: state EMPTY, out_valid_o = 0, out_data_o = NOP_VALUE, skid = NOP_VALUE, occupancy_o = 0, in_ready_o = 1 in the following cycle.
REQ-031 rst asserted mid-operation (any state) SHALL discard all entries with no pop reported downstream.

Verification
REQ-032 Reset then idle -> out_valid_o=0, out_data_o=32'h00000013, in_ready_o=1, occupancy_o=0.
REQ-033 Stream A1,A2,A3 with out_ready_i=1 -> outputs A1,A2,A3 on consecutive cycles, each one cycle after its push, occupancy_o stays 1.
REQ-034 Push B1,B2 with out_ready_i=0 -> occupancy_o=2, in_ready_o=0, out_data_o=B1 held; raise out_ready_i -> B1 then B2, in_ready_o=1 after the first pop.
REQ-035 State TWO (C1,C2), assert flush_i with in_valid_i=1 (C3) -> next cycle occupancy_o=0, out_valid_o=0, out_data_o=NOP_VALUE; C3 is never output.
REQ-036 SKID=0, out_valid_o=1 with D1, out_ready_i=1, push D2 same cycle -> in_ready_o=1 combinationally, D2 output next cycle, no bubble.
REQ-037 Random valid/ready over 10000 cycles, WIDTH=8 and WIDTH=64 -> scoreboard shows in-order delivery and no loss/duplication; out_data_o stable while stalled.
